csr_access_unit: RTL and testbench

Initiator side of the CSR read/modify/write protocol. It accepts a CSR instruction from execute and issues a read request to the CSR file. It waits for the returned read data and valid, computes the RW/RS/RC result, and issues the write. It then delivers CSR_read_data / CSR_read_data_valid to the writeback stage for the rd update. It stalls execute while a transaction is in flight.

---
 rtl/csr_access_unit_pkg.sv | 27 ++
 rtl/csr_access_unit_if.sv | 43 ++++
 rtl/csr_access_unit_modify_logic.sv | 23 ++
 rtl/csr_access_unit.sv | 133 +++++++++++++
 tb/tb_csr_access_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared definitions for the CSR access unit: op and FSM encodings, address width.
package csr_access_unit_pkg;

    localparam int CSR_ADDR_W = 12;

    typedef enum logic [1:0] {
        CSR_OP_ILL = 2'b00,
        CSR_OP_RW  = 2'b01,
        CSR_OP_RS  = 2'b10,
        CSR_OP_RC  = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4,
        ST_FAULT = 3'd5
    } csr_state_e;

    // Set/clear with a zero source must not disturb the CSR, so the write is skipped.
    function automatic logic op_skips_write(csr_op_e op, logic src_is_x0);
        return ((op == CSR_OP_RS) || (op == CSR_OP_RC)) && src_is_x0;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundle of the execute request, CSR file read/write, and writeback response signals.
interface csr_access_unit_if
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [1:0]            req_op;
    logic [CSR_ADDR_W-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_rd_is_x0;
    logic                  req_src_is_x0;
    logic                  flush;
    logic                  csr_read_en;
    logic [CSR_ADDR_W-1:0] csr_read_addr;
    logic [DATA_WIDTH-1:0] csr_rdata;
    logic                  csr_rdata_valid;
    logic                  csr_write_en;
    logic [CSR_ADDR_W-1:0] csr_write_addr;
    logic [DATA_WIDTH-1:0] csr_write_data;
    logic [DATA_WIDTH-1:0] CSR_read_data;
    logic                  CSR_read_data_valid;
    logic                  csr_fault;
    logic                  scan;

    // The access unit: it drives the CSR bus and the writeback response.
    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_rd_is_x0, req_src_is_x0,
        input  flush, csr_rdata, csr_rdata_valid, scan,
        output req_ready, csr_read_en, csr_read_addr, csr_write_en, csr_write_addr,
        output csr_write_data, CSR_read_data, CSR_read_data_valid, csr_fault
    );

    // The surroundings: execute, CSR file and writeback.
    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_rd_is_x0, req_src_is_x0,
        output flush, csr_rdata, csr_rdata_valid, scan,
        input  req_ready, csr_read_en, csr_read_addr, csr_write_en, csr_write_addr,
        input  csr_write_data, CSR_read_data, CSR_read_data_valid, csr_fault
    );

endinterface

// File: rtl/csr_access_unit_modify_logic.sv
// Combinational RW/RS/RC merge of the old CSR value with the source operand.
module csr_modify_logic
    import csr_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  csr_op_e               i_op,
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_wvalue
);

    // Select the new CSR value for the requested operation.
    always_comb begin
        o_wvalue = i_wdata;
        case (i_op)
            CSR_OP_RS: o_wvalue = i_old | i_wdata;
            CSR_OP_RC: o_wvalue = i_old & ~i_wdata;
            default:   o_wvalue = i_wdata;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR read/modify/write protocol; stalls execute while busy.
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int CORE            = 0,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int SCAN_CYCLES_MIN = 0,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic               clock,
    input  logic               reset,
    csr_access_unit_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    csr_state_e            r_state;
    csr_state_e            w_state_next;
    csr_op_e               r_op;
    logic [CSR_ADDR_W-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_old;
    logic                  r_rd_x0;
    logic                  r_src_x0;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_accept;
    logic                  w_rdata_take;
    logic                  w_timeout;
    logic [DATA_WIDTH-1:0] w_write_value;
    csr_op_e               w_req_op;

    assign w_req_op     = csr_op_e'(bus.req_op);
    // A flush in IDLE blocks the handshake so a squashed instruction never starts.
    assign w_accept     = (r_state == ST_IDLE) && bus.req_valid && !bus.flush;
    assign w_rdata_take = (r_state == ST_WAIT) && bus.csr_rdata_valid && !bus.flush;
    // Counter holds the number of WAIT cycles already elapsed, so this is the last one.
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; returning data takes priority over the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_op == CSR_OP_ILL) begin
                        w_state_next = ST_FAULT;
                    end else if ((w_req_op == CSR_OP_RW) && bus.req_rd_is_x0) begin
                        w_state_next = ST_WRITE;
                    end else begin
                        w_state_next = ST_READ;
                    end
                end
            end
            ST_READ: begin
                w_state_next = bus.flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.flush) begin
                    w_state_next = ST_IDLE;
                end else if (bus.csr_rdata_valid) begin
                    w_state_next = op_skips_write(r_op, r_src_x0) ? ST_RESP : ST_WRITE;
                end else if (w_timeout) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_WRITE: w_state_next = ST_RESP;
            ST_RESP:  w_state_next = ST_IDLE;
            ST_FAULT: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Latch the request on accept, capture the old value, and run the wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_op     <= CSR_OP_ILL;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_old    <= '0;
            r_rd_x0  <= 1'b0;
            r_src_x0 <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= w_req_op;
                r_addr   <= bus.req_addr;
                r_wdata  <= bus.req_wdata;
                r_rd_x0  <= bus.req_rd_is_x0;
                r_src_x0 <= bus.req_src_is_x0;
                r_old    <= '0;
            end
            if (r_state == ST_READ) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_rdata_take) begin
                r_old <= bus.csr_rdata;
            end
        end
    end

    csr_modify_logic #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_modify (
        .i_op     (r_op),
        .i_old    (r_old),
        .i_wdata  (r_wdata),
        .o_wvalue (w_write_value)
    );

    // Outputs decode straight from the state so an asynchronous reset drops them at once.
    assign bus.req_ready           = reset && (r_state == ST_IDLE);
    assign bus.csr_read_en         = (r_state == ST_READ);
    assign bus.csr_read_addr       = (r_state == ST_READ) ? r_addr : '0;
    assign bus.csr_write_en        = (r_state == ST_WRITE);
    assign bus.csr_write_addr      = (r_state == ST_WRITE) ? r_addr : '0;
    assign bus.csr_write_data      = (r_state == ST_WRITE) ? w_write_value : '0;
    assign bus.CSR_read_data       = (r_state == ST_RESP) ? r_old : '0;
    assign bus.CSR_read_data_valid = (r_state == ST_RESP) && !((r_op == CSR_OP_RW) && r_rd_x0);
    assign bus.csr_fault           = (r_state == ST_FAULT);

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed table-driven bench for csr_access_unit; the bench plays execute, CSR file and writeback.
module tb_csr_access_unit;
    import csr_access_unit_pkg::*;

    localparam int DW = 32;

    logic clock;
    logic reset;

    csr_access_unit_if #(.DATA_WIDTH(DW)) bus ();

    csr_access_unit #(
        .CORE            (0),
        .DATA_WIDTH      (DW),
        .TIMEOUT_CYCLES  (16),
        .SCAN_CYCLES_MIN (0),
        .SCAN_CYCLES_MAX (1000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        rd_x0;
        logic        src_x0;
        logic [31:0] csr_val;
        int          rv_delay;    // cycles after read_en that rdata_valid appears; 0 = never
        int          flush_cycle; // cycle in which flush is high; 0 = with the request, -1 = none
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wr_data;
        int          exp_resp;
        logic [31:0] exp_resp_data;
        int          exp_resp_cycle;
        int          exp_fault;
        int          exp_done;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    int          rd_cnt, wr_cnt, resp_cnt, fault_cnt, overlap, done_cycle, resp_cycle;
    logic [11:0] rd_addr, wr_addr;
    logic [31:0] wr_data, resp_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int valid_at;
        rd_cnt = 0; wr_cnt = 0; resp_cnt = 0; fault_cnt = 0; overlap = 0;
        done_cycle = 0; resp_cycle = 0; valid_at = 0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; resp_data = '0;
        @(negedge clock);
        bus.req_valid     = 1'b1;
        bus.req_op        = v.op;
        bus.req_addr      = v.addr;
        bus.req_wdata     = v.wdata;
        bus.req_rd_is_x0  = v.rd_x0;
        bus.req_src_is_x0 = v.src_x0;
        bus.csr_rdata     = v.csr_val;
        bus.flush         = (v.flush_cycle == 0);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            if (bus.csr_read_en) begin
                rd_cnt++;
                rd_addr = bus.csr_read_addr;
                if (v.rv_delay > 0) valid_at = i + v.rv_delay;
            end
            if (bus.csr_write_en) begin
                wr_cnt++;
                wr_data = bus.csr_write_data;
                wr_addr = bus.csr_write_addr;
            end
            if (bus.csr_read_en && bus.csr_write_en) overlap++;
            if (bus.CSR_read_data_valid) begin
                resp_cnt++;
                resp_data  = bus.CSR_read_data;
                resp_cycle = i;
            end
            if (bus.csr_fault) fault_cnt++;
            if (bus.req_ready && done_cycle == 0) done_cycle = i;
            bus.csr_rdata_valid = (valid_at != 0) && (i == valid_at);
            bus.flush           = (i == v.flush_cycle);
            if (done_cycle != 0 && i > valid_at) break;
        end
        bus.csr_rdata_valid = 1'b0;
        bus.flush           = 1'b0;

        $display("txn %s: rd=%0d wr=%0d wdata=%08h resp=%0d rdata=%08h resp_cyc=%0d fault=%0d ready_cyc=%0d",
                 v.name, rd_cnt, wr_cnt, wr_data, resp_cnt, resp_data, resp_cycle, fault_cnt, done_cycle);
        chk({v.name, " read_count"},  64'(rd_cnt),    64'(v.exp_rd));
        chk({v.name, " write_count"}, 64'(wr_cnt),    64'(v.exp_wr));
        chk({v.name, " resp_count"},  64'(resp_cnt),  64'(v.exp_resp));
        chk({v.name, " fault_count"}, 64'(fault_cnt), 64'(v.exp_fault));
        chk({v.name, " ready_cycle"}, 64'(done_cycle), 64'(v.exp_done));
        chk({v.name, " strobe_overlap"}, 64'(overlap), 64'd0);
        if (v.exp_rd > 0)   chk({v.name, " read_addr"}, 64'(rd_addr), 64'(v.addr));
        if (v.exp_wr > 0) begin
            chk({v.name, " write_addr"}, 64'(wr_addr), 64'(v.addr));
            chk({v.name, " write_data"}, 64'(wr_data), 64'(v.exp_wr_data));
        end
        if (v.exp_resp > 0) begin
            chk({v.name, " resp_data"},  64'(resp_data),  64'(v.exp_resp_data));
            chk({v.name, " resp_cycle"}, 64'(resp_cycle), 64'(v.exp_resp_cycle));
        end
    endtask

    initial begin
        //          name        op     addr    wdata         rdx0 srcx0 csr_val      dly flush rd wr wr_data       rsp rsp_data     rcyc flt done
        vecs.push_back('{"rw_basic",  2'b01, 12'h340, 32'hDEADBEEF, 0, 0, 32'h12345678, 1, -1, 1, 1, 32'hDEADBEEF, 1, 32'h12345678, 4, 0, 5});
        vecs.push_back('{"rs_basic",  2'b10, 12'h300, 32'h0000000F, 0, 0, 32'h000000F0, 1, -1, 1, 1, 32'h000000FF, 1, 32'h000000F0, 4, 0, 5});
        vecs.push_back('{"rc_basic",  2'b11, 12'h304, 32'h0000000F, 0, 0, 32'h000000FF, 1, -1, 1, 1, 32'h000000F0, 1, 32'h000000FF, 4, 0, 5});
        vecs.push_back('{"rs_src_x0", 2'b10, 12'h305, 32'h00000000, 0, 1, 32'h000000AA, 1, -1, 1, 0, 32'h0,        1, 32'h000000AA, 3, 0, 4});
        vecs.push_back('{"rw_rd_x0",  2'b01, 12'h341, 32'h00000055, 1, 0, 32'h99999999, 1, -1, 0, 1, 32'h00000055, 0, 32'h0,        0, 0, 3});
        vecs.push_back('{"timeout",   2'b10, 12'h342, 32'h00000001, 0, 0, 32'h00000000, 0, -1, 1, 0, 32'h0,        0, 32'h0,        0, 1, 19});
        vecs.push_back('{"valid_at_limit", 2'b11, 12'h343, 32'h0F0F0000, 0, 0, 32'hFFFF0000, 16, -1, 1, 1, 32'hF0F00000, 1, 32'hFFFF0000, 19, 0, 20});
        vecs.push_back('{"illegal_op", 2'b00, 12'h344, 32'h00000001, 0, 0, 32'h0, 1, -1, 0, 0, 32'h0, 0, 32'h0, 0, 1, 2});
        vecs.push_back('{"rs_delay3", 2'b10, 12'h345, 32'h7FFFFFFE, 0, 0, 32'h80000001, 3, -1, 1, 1, 32'hFFFFFFFF, 1, 32'h80000001, 6, 0, 7});
        vecs.push_back('{"flush_wait", 2'b01, 12'h346, 32'h12121212, 0, 0, 32'h34343434, 3, 2, 1, 0, 32'h0, 0, 32'h0, 0, 0, 3});
        vecs.push_back('{"rw_after_flush", 2'b01, 12'h347, 32'hCAFEF00D, 0, 0, 32'h0BADBEEF, 1, -1, 1, 1, 32'hCAFEF00D, 1, 32'h0BADBEEF, 4, 0, 5});
        vecs.push_back('{"flush_read", 2'b11, 12'h348, 32'h000000FF, 0, 0, 32'hFFFFFFFF, 1, 1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 2});
        vecs.push_back('{"flush_write_ignored", 2'b01, 12'h349, 32'h00000777, 0, 0, 32'h00000333, 1, 3, 1, 1, 32'h00000777, 1, 32'h00000333, 4, 0, 5});
        vecs.push_back('{"flush_with_req", 2'b01, 12'h34A, 32'h00000001, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1});

        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
        bus.req_rd_is_x0 = 1'b0; bus.req_src_is_x0 = 1'b0; bus.flush = 1'b0;
        bus.csr_rdata = '0; bus.csr_rdata_valid = 1'b0; bus.scan = 1'b0;

        // Reset state: every output low, including req_ready while reset is held.
        repeat (3) @(negedge clock);
        chk("reset_ready_low", 64'(bus.req_ready), 64'd0);
        chk("reset_outputs_zero",
            64'(|{bus.csr_read_en, bus.csr_read_addr, bus.csr_write_en, bus.csr_write_addr,
                  bus.csr_write_data, bus.CSR_read_data, bus.CSR_read_data_valid, bus.csr_fault}), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_reset_ready", 64'(bus.req_ready), 64'd1);

        foreach (vecs[k]) run_vec(vecs[k]);

        // Reset asserted while the write strobe is up: it must drop at once and no response follows.
        @(negedge clock);
        bus.req_valid = 1'b1; bus.req_op = 2'b01; bus.req_addr = 12'h300;
        bus.req_wdata = 32'h11111111; bus.req_rd_is_x0 = 1'b0; bus.req_src_is_x0 = 1'b0;
        bus.csr_rdata = 32'h22222222;
        @(negedge clock);
        bus.req_valid = 1'b0;
        chk("rstwr_read_en", 64'(bus.csr_read_en), 64'd1);
        @(negedge clock);
        bus.csr_rdata_valid = 1'b1;
        @(negedge clock);
        bus.csr_rdata_valid = 1'b0;
        chk("rstwr_write_en_before", 64'(bus.csr_write_en), 64'd1);
        reset = 1'b0;
        #1;
        chk("rstwr_write_en_dropped", 64'(bus.csr_write_en), 64'd0);
        chk("rstwr_outputs_zero",
            64'(|{bus.req_ready, bus.csr_read_en, bus.csr_read_addr, bus.csr_write_en, bus.csr_write_addr,
                  bus.csr_write_data, bus.CSR_read_data, bus.CSR_read_data_valid, bus.csr_fault}), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        begin
            int stray;
            stray = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                stray += int'(bus.csr_write_en) + int'(bus.CSR_read_data_valid) +
                         int'(bus.csr_read_en) + int'(bus.csr_fault) + int'(!bus.req_ready);
            end
            $display("txn reset_in_write: stray_activity=%0d ready=%0d", stray, bus.req_ready);
            chk("rstwr_idle_after_release", 64'(stray), 64'd0);
        end

        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
